ocm_burst_scheduler: RTL and testbench

Single-clock AXI-side scheduler that shares one AXI master port between the sample-to-AXI write stream and the AXI-to-sample read stream. It grants 16-beat bursts to the two requesters and keeps one transaction in flight at a time. It owns the two OCM ring pointers and drives the AW/AR address channels. It also tracks write-response and read-data completion and keeps burst and error counters. It sits in the AXI_clk domain between the per-direction buffer movers and the AXI HP/OCM port.

---
 rtl/ocm_burst_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_ocm_burst_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocm_burst_scheduler.sv
// ocm_burst_scheduler
//
// Shares one AXI master port between the sample-to-AXI write stream and the
// AXI-to-sample read stream. Grants 16-beat (64-byte) bursts, keeps exactly
// one transaction in flight, owns both OCM ring pointers and tracks
// completion, burst counts and errors.
//
// Ports:
//   AXI_clk, rst          clock, synchronous active-high reset
//   sync                  pulse: restart ring pointers and burst counters
//   wr_req / rd_req       level requests from the buffer movers
//   wr_gnt / rd_gnt       one-cycle pulse after the AW / AR handshake
//   wr_done / rd_done     one-cycle pulse at burst completion
//   AXI_aw*, AXI_b*       write address / response channels
//   AXI_ar*, AXI_r*       read address / data channels
//   wr_cnt / rd_cnt       completed bursts since reset or sync
//   err_cnt               saturating error count (one per failed burst)
//   busy                  high whenever the scheduler is not idle
module ocm_burst_scheduler #(
    parameter logic [31:0] wr_haddr  = 32'hfffc0000,
    parameter logic [31:0] rd_haddr  = 32'hfffd0000,
    parameter int          ocm_width = 16,
    parameter int          timeout   = 1024
) (
    input  logic        AXI_clk,
    input  logic        rst,
    input  logic        sync,
    input  logic        wr_req,
    input  logic        rd_req,
    output logic        wr_gnt,
    output logic        rd_gnt,
    output logic        wr_done,
    output logic        rd_done,
    output logic [31:0] AXI_awaddr,
    output logic        AXI_awvalid,
    input  logic        AXI_awready,
    input  logic        AXI_bvalid,
    input  logic [1:0]  AXI_bresp,
    output logic [31:0] AXI_araddr,
    output logic        AXI_arvalid,
    input  logic        AXI_arready,
    input  logic        AXI_rvalid,
    input  logic        AXI_rlast,
    input  logic [1:0]  AXI_rresp,
    output logic        AXI_rready,
    output logic [31:0] wr_cnt,
    output logic [31:0] rd_cnt,
    output logic [15:0] err_cnt,
    output logic        busy
);

    localparam logic [31:0] PTR_MASK    = (32'd1 << ocm_width) - 32'd1;
    localparam logic [31:0] BURST_BYTES = 32'd64;
    localparam int          TW          = (timeout > 1) ? $clog2(timeout) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(timeout - 1);
    localparam logic [4:0]  LAST_BEAT   = 5'd15;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t        state;
    logic [31:0]   wr_ptr;
    logic [31:0]   rd_ptr;
    logic          sync_pending;
    logic          last_wr;      // 1: write served last, 0: read served last
    logic [TW-1:0] tmo_cnt;
    logic          txn_err;      // sticky per-transaction error flag
    logic [4:0]    beat_cnt;
    logic          tmo_reach;
    logic          beat_bad;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] ptr_next(input logic [31:0] p);
        return (p + BURST_BYTES) & PTR_MASK;
    endfunction

    // The timer stops at its last value; the sticky flag makes it count once.
    assign tmo_reach = (tmo_cnt == TMO_LAST);
    assign beat_bad  = (AXI_rresp != 2'b00) || (AXI_rlast && (beat_cnt != LAST_BEAT));

    always_ff @(posedge AXI_clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sync_pending <= 1'b0;
            last_wr      <= 1'b0;
            tmo_cnt      <= '0;
            txn_err      <= 1'b0;
            beat_cnt     <= '0;
            wr_gnt       <= 1'b0;
            rd_gnt       <= 1'b0;
            wr_done      <= 1'b0;
            rd_done      <= 1'b0;
            AXI_awaddr   <= wr_haddr;
            AXI_awvalid  <= 1'b0;
            AXI_araddr   <= rd_haddr;
            AXI_arvalid  <= 1'b0;
            AXI_rready   <= 1'b0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            err_cnt      <= '0;
            busy         <= 1'b0;
        end else begin
            wr_gnt  <= 1'b0;
            rd_gnt  <= 1'b0;
            wr_done <= 1'b0;
            rd_done <= 1'b0;

            if (sync) begin
                sync_pending <= 1'b1;
            end

            if (state != IDLE) begin
                if (!tmo_reach) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
                if (tmo_reach) begin
                    txn_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (sync_pending) begin
                        // Restart cycle: no grant is issued here.
                        wr_ptr       <= '0;
                        rd_ptr       <= '0;
                        wr_cnt       <= '0;
                        rd_cnt       <= '0;
                        sync_pending <= sync;
                    end else if (wr_req && (!rd_req || !last_wr)) begin
                        state       <= WR_ADDR;
                        busy        <= 1'b1;
                        AXI_awvalid <= 1'b1;
                        AXI_awaddr  <= wr_haddr | wr_ptr;
                        last_wr     <= 1'b1;
                        tmo_cnt     <= '0;
                        txn_err     <= 1'b0;
                    end else if (rd_req) begin
                        state       <= RD_ADDR;
                        busy        <= 1'b1;
                        AXI_arvalid <= 1'b1;
                        AXI_araddr  <= rd_haddr | rd_ptr;
                        last_wr     <= 1'b0;
                        tmo_cnt     <= '0;
                        txn_err     <= 1'b0;
                        beat_cnt    <= '0;
                    end
                end

                WR_ADDR: begin
                    if (AXI_awready) begin
                        AXI_awvalid <= 1'b0;
                        wr_gnt      <= 1'b1;
                        wr_ptr      <= ptr_next(wr_ptr);
                        state       <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (AXI_bvalid) begin
                        wr_done <= 1'b1;
                        wr_cnt  <= wr_cnt + 32'd1;
                        if (txn_err || tmo_reach || (AXI_bresp != 2'b00)) begin
                            err_cnt <= sat_inc(err_cnt);
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                RD_ADDR: begin
                    if (AXI_arready) begin
                        AXI_arvalid <= 1'b0;
                        rd_gnt      <= 1'b1;
                        rd_ptr      <= ptr_next(rd_ptr);
                        AXI_rready  <= 1'b1;
                        state       <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (AXI_rvalid) begin
                        // Saturate so an overlong burst never aliases onto beat 16.
                        if (beat_cnt != 5'd31) begin
                            beat_cnt <= beat_cnt + 5'd1;
                        end
                        if (AXI_rlast) begin
                            rd_done    <= 1'b1;
                            rd_cnt     <= rd_cnt + 32'd1;
                            AXI_rready <= 1'b0;
                            if (txn_err || tmo_reach || beat_bad) begin
                                err_cnt <= sat_inc(err_cnt);
                            end
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (beat_bad) begin
                            txn_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ocm_burst_scheduler.sv
// Testbench for ocm_burst_scheduler: directed AXI slave sequencing from the
// main process, expected addresses / grants / completions queued at issue
// time and checked by a negedge monitor.
module tb_ocm_burst_scheduler;

    logic        clk;
    logic        rst;
    logic        sync;
    logic        wr_req;
    logic        rd_req;
    logic        wr_gnt;
    logic        rd_gnt;
    logic        wr_done;
    logic        rd_done;
    logic [31:0] AXI_awaddr;
    logic        AXI_awvalid;
    logic        AXI_awready;
    logic        AXI_bvalid;
    logic [1:0]  AXI_bresp;
    logic [31:0] AXI_araddr;
    logic        AXI_arvalid;
    logic        AXI_arready;
    logic        AXI_rvalid;
    logic        AXI_rlast;
    logic [1:0]  AXI_rresp;
    logic        AXI_rready;
    logic [31:0] wr_cnt;
    logic [31:0] rd_cnt;
    logic [15:0] err_cnt;
    logic        busy;

    ocm_burst_scheduler dut (
        .AXI_clk     (clk),
        .rst         (rst),
        .sync        (sync),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .wr_gnt      (wr_gnt),
        .rd_gnt      (rd_gnt),
        .wr_done     (wr_done),
        .rd_done     (rd_done),
        .AXI_awaddr  (AXI_awaddr),
        .AXI_awvalid (AXI_awvalid),
        .AXI_awready (AXI_awready),
        .AXI_bvalid  (AXI_bvalid),
        .AXI_bresp   (AXI_bresp),
        .AXI_araddr  (AXI_araddr),
        .AXI_arvalid (AXI_arvalid),
        .AXI_arready (AXI_arready),
        .AXI_rvalid  (AXI_rvalid),
        .AXI_rlast   (AXI_rlast),
        .AXI_rresp   (AXI_rresp),
        .AXI_rready  (AXI_rready),
        .wr_cnt      (wr_cnt),
        .rd_cnt      (rd_cnt),
        .err_cnt     (err_cnt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_rd;
        logic [31:0] cnt;
        logic [15:0] err;
    } done_t;

    logic [31:0] aw_q[$];
    logic [31:0] ar_q[$];
    logic        gnt_q[$];
    done_t       done_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        prev_aw_hs, prev_ar_hs, prev_awvalid, prev_arvalid;
    logic [31:0] prev_awaddr, prev_araddr;

    always @(negedge clk) begin
        logic  g;
        done_t d;
        if (rst) begin
            prev_aw_hs   = 1'b0;
            prev_ar_hs   = 1'b0;
            prev_awvalid = 1'b0;
            prev_arvalid = 1'b0;
            prev_awaddr  = '0;
            prev_araddr  = '0;
        end else begin
            if (prev_awvalid && !prev_aw_hs) begin
                chk("awvalid_hold", AXI_awvalid, 1);
                chk("awaddr_hold", AXI_awaddr, prev_awaddr);
            end
            if (prev_arvalid && !prev_ar_hs) begin
                chk("arvalid_hold", AXI_arvalid, 1);
                chk("araddr_hold", AXI_araddr, prev_araddr);
            end
            if (wr_gnt || prev_aw_hs) chk("wr_gnt_timing", wr_gnt, prev_aw_hs);
            if (rd_gnt || prev_ar_hs) chk("rd_gnt_timing", rd_gnt, prev_ar_hs);
            if (wr_gnt || rd_gnt) begin
                if (gnt_q.size() == 0) fail_now("gnt_unexpected");
                else begin
                    g = gnt_q.pop_front();
                    chk("gnt_dir_is_rd", rd_gnt, g);
                end
            end
            if (AXI_awvalid && AXI_awready) begin
                if (aw_q.size() == 0) fail_now("aw_unexpected");
                else chk("awaddr", AXI_awaddr, aw_q.pop_front());
            end
            if (AXI_arvalid && AXI_arready) begin
                if (ar_q.size() == 0) fail_now("ar_unexpected");
                else chk("araddr", AXI_araddr, ar_q.pop_front());
            end
            if (wr_done || rd_done) begin
                if (done_q.size() == 0) fail_now("done_unexpected");
                else begin
                    d = done_q.pop_front();
                    chk("done_is_rd", rd_done, d.is_rd);
                    chk("done_cnt", d.is_rd ? rd_cnt : wr_cnt, d.cnt);
                    chk("err_cnt", err_cnt, d.err);
                    chk("busy_at_done", busy, 0);
                end
            end
            prev_aw_hs   = AXI_awvalid && AXI_awready;
            prev_ar_hs   = AXI_arvalid && AXI_arready;
            prev_awvalid = AXI_awvalid;
            prev_arvalid = AXI_arvalid;
            prev_awaddr  = AXI_awaddr;
            prev_araddr  = AXI_araddr;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_burst(input bit is_rd, input logic [31:0] addr,
                                input logic [31:0] cnt, input logic [15:0] err);
        done_t d;
        if (is_rd) ar_q.push_back(addr);
        else aw_q.push_back(addr);
        gnt_q.push_back(is_rd);
        d.is_rd = is_rd;
        d.cnt   = cnt;
        d.err   = err;
        done_q.push_back(d);
    endtask

    task automatic wait_valid(input bit is_rd, output bit ok);
        int n = 0;
        while (!(is_rd ? AXI_arvalid : AXI_awvalid) && n < 100) begin
            tick();
            n++;
        end
        ok = is_rd ? AXI_arvalid : AXI_awvalid;
        if (!ok) fail_now("wait_valid_timeout");
    endtask

    // Plays the AXI slave for one burst: address stall, optional sync pulse
    // during the stall, response delay, then B response or nbeats R beats.
    task automatic run_burst(input bit is_rd, input int stall, input int sync_at,
                             input int delay, input logic [1:0] resp,
                             input int nbeats, input bit drop);
        bit ok;
        wait_valid(is_rd, ok);
        if (!ok) return;
        for (int i = 0; i < stall; i++) begin
            if (i == sync_at) sync = 1'b1;
            tick();
            sync = 1'b0;
        end
        if (is_rd) AXI_arready = 1'b1;
        else AXI_awready = 1'b1;
        tick();
        AXI_arready = 1'b0;
        AXI_awready = 1'b0;
        if (drop) begin
            if (is_rd) rd_req = 1'b0;
            else wr_req = 1'b0;
        end
        for (int i = 0; i < delay; i++) tick();
        if (!is_rd) begin
            AXI_bvalid = 1'b1;
            AXI_bresp  = resp;
            tick();
            AXI_bvalid = 1'b0;
            AXI_bresp  = 2'b00;
        end else begin
            for (int b = 0; b < nbeats; b++) begin
                AXI_rvalid = 1'b1;
                AXI_rlast  = (b == nbeats - 1);
                AXI_rresp  = resp;
                tick();
            end
            AXI_rvalid = 1'b0;
            AXI_rlast  = 1'b0;
            AXI_rresp  = 2'b00;
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_gnt"}, wr_gnt, 0);
        chk({tag, "_rd_gnt"}, rd_gnt, 0);
        chk({tag, "_wr_done"}, wr_done, 0);
        chk({tag, "_rd_done"}, rd_done, 0);
        chk({tag, "_awaddr"}, AXI_awaddr, 32'hfffc0000);
        chk({tag, "_awvalid"}, AXI_awvalid, 0);
        chk({tag, "_araddr"}, AXI_araddr, 32'hfffd0000);
        chk({tag, "_arvalid"}, AXI_arvalid, 0);
        chk({tag, "_rready"}, AXI_rready, 0);
        chk({tag, "_wr_cnt"}, wr_cnt, 0);
        chk({tag, "_rd_cnt"}, rd_cnt, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; sync = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        AXI_awready = 1'b0; AXI_bvalid = 1'b0; AXI_bresp = 2'b00;
        AXI_arready = 1'b0; AXI_rvalid = 1'b0; AXI_rlast = 1'b0; AXI_rresp = 2'b00;
        do_reset();
        check_reset_outputs("reset");

        // Write alone, two bursts back to back.
        wr_req = 1'b1;
        expect_burst(0, 32'hfffc0000, 1, 0);
        run_burst(0, 0, -1, 4, 2'b00, 0, 0);
        expect_burst(0, 32'hfffc0040, 2, 0);
        run_burst(0, 0, -1, 4, 2'b00, 0, 1);

        // Both requests held from reset: W, R, W, R.
        wr_req = 1'b1; rd_req = 1'b1;
        do_reset();
        expect_burst(0, 32'hfffc0000, 1, 0);
        run_burst(0, 0, -1, 2, 2'b00, 0, 0);
        expect_burst(1, 32'hfffd0000, 1, 0);
        run_burst(1, 0, -1, 1, 2'b00, 16, 0);
        expect_burst(0, 32'hfffc0040, 2, 0);
        run_burst(0, 0, -1, 2, 2'b00, 0, 1);
        expect_burst(1, 32'hfffd0040, 2, 0);
        run_burst(1, 0, -1, 1, 2'b00, 16, 1);

        // Ring wrap: 1025 writes.
        wr_req = 1'b0; rd_req = 1'b0;
        do_reset();
        wr_req = 1'b1;
        for (int i = 1; i <= 1025; i++) begin
            logic [31:0] a;
            if (i == 1024) a = 32'hfffcffc0;
            else if (i == 1025) a = 32'hfffc0000;
            else a = 32'hfffc0000 | (((i - 1) * 64) % 65536);
            expect_burst(0, a, i, 0);
            run_burst(0, 0, -1, 0, 2'b00, 0, (i == 1025));
        end

        // Stalled handshake with sync during the stall.
        wr_req = 1'b1;
        expect_burst(0, 32'hfffc0040, 1026, 0);
        run_burst(0, 20, 7, 2, 2'b00, 0, 0);
        expect_burst(0, 32'hfffc0000, 1, 0);
        run_burst(0, 0, -1, 2, 2'b00, 0, 1);

        // Errors: bad bresp, early rlast, late bvalid.
        wr_req = 1'b1;
        expect_burst(0, 32'hfffc0040, 2, 1);
        run_burst(0, 0, -1, 3, 2'b10, 0, 1);
        rd_req = 1'b1;
        expect_burst(1, 32'hfffd0000, 1, 2);
        run_burst(1, 0, -1, 1, 2'b00, 15, 1);
        wr_req = 1'b1;
        expect_burst(0, 32'hfffc0080, 3, 3);
        run_burst(0, 0, -1, 1100, 2'b00, 0, 1);

        // Reset in the middle of a read.
        begin
            bit ok;
            for (int i = 0; i < 3; i++) tick();
            rd_req = 1'b1;
            ar_q.push_back(32'hfffd0040);
            gnt_q.push_back(1'b1);
            wait_valid(1, ok);
            AXI_arready = 1'b1;
            tick();
            AXI_arready = 1'b0;
            rd_req = 1'b0;
            for (int b = 0; b < 3; b++) begin
                AXI_rvalid = 1'b1;
                tick();
            end
            AXI_rvalid = 1'b0;
            rst = 1'b1;
            tick();
            check_reset_outputs("midread_rst");
            rst = 1'b0;
        end
        rd_req = 1'b1;
        expect_burst(1, 32'hfffd0000, 1, 0);
        run_burst(1, 0, -1, 1, 2'b00, 16, 1);
        wr_req = 1'b1;
        expect_burst(0, 32'hfffc0000, 1, 0);
        run_burst(0, 0, -1, 2, 2'b00, 0, 1);

        for (int i = 0; i < 5; i++) tick();
        chk("aw_q_left", aw_q.size(), 0);
        chk("ar_q_left", ar_q.size(), 0);
        chk("gnt_q_left", gnt_q.size(), 0);
        chk("done_q_left", done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
